// File: rtl/arm_pkg.sv
// arm_pkg: shared constants, ALU command codes, mode/opcode constants and the
// decoded-control bundle used across the ARM core pipeline.
package arm_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 4;
    localparam int CMD_W     = 4;

    // ALU execute commands produced by the control unit
    localparam logic [CMD_W-1:0] ALU_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] ALU_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] ALU_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] ALU_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] ALU_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] ALU_AND = 4'b0110;
    localparam logic [CMD_W-1:0] ALU_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] ALU_EOR = 4'b1000;

    // Instruction mode field
    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    // Data-processing opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef struct packed {
        logic [CMD_W-1:0] exe_cmd;
        logic             mem_read;
        logic             mem_write;
        logic             wb_en;
        logic             branch;
        logic             s;
    } ctrl_t;

endpackage

// File: rtl/id_exe_perf_counter.sv
// id_exe_perf_counter: 32-bit wrapping event counter with synchronous active-low reset.
// Ports: clk, rst_n (sync, active-low), inc (count this edge), count (current value).
module id_exe_perf_counter
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (inc)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register with freeze, flush and bubble handling.
// Ports: clk, rst_n (sync, active-low), freeze/flush/bubble controls, valid_in, the ID-stage
// control bits, operands, immediates and register indices (*_in), their registered copies
// (*_out) and valid_out. Optional macro ID_EXE_PERF_CNT_EN adds bubble_cnt/flush_cnt/freeze_cnt.
module id_exe_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W    = arm_pkg::DATA_W,
    parameter int REG_IDX_W = arm_pkg::REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 bubble,
    input  logic                 valid_in,
    input  logic [DATA_W-1:0]    pc_in,
    input  logic [CMD_W-1:0]     exe_cmd_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic                 wb_en_in,
    input  logic                 branch_in,
    input  logic                 s_in,
    input  logic [DATA_W-1:0]    val_rn_in,
    input  logic [DATA_W-1:0]    val_rm_in,
    input  logic                 imm_in,
    input  logic [11:0]          shift_operand_in,
    input  logic [23:0]          simm24_in,
    input  logic [REG_IDX_W-1:0] dest_in,
    input  logic [REG_IDX_W-1:0] src1_in,
    input  logic [REG_IDX_W-1:0] src2_in,
    input  logic                 carry_in,
    output logic                 valid_out,
    output logic [DATA_W-1:0]    pc_out,
    output logic [CMD_W-1:0]     exe_cmd_out,
    output logic                 mem_read_out,
    output logic                 mem_write_out,
    output logic                 wb_en_out,
    output logic                 branch_out,
    output logic                 s_out,
    output logic [DATA_W-1:0]    val_rn_out,
    output logic [DATA_W-1:0]    val_rm_out,
    output logic                 imm_out,
    output logic [11:0]          shift_operand_out,
    output logic [23:0]          simm24_out,
    output logic [REG_IDX_W-1:0] dest_out,
    output logic [REG_IDX_W-1:0] src1_out,
    output logic [REG_IDX_W-1:0] src2_out,
    output logic                 carry_out
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [31:0]          bubble_cnt,
    output logic [31:0]          flush_cnt,
    output logic [31:0]          freeze_cnt
`endif
);

    ctrl_t ctrl_in, ctrl_q;
    logic  live;

    assign ctrl_in = '{exe_cmd: exe_cmd_in, mem_read: mem_read_in, mem_write: mem_write_in,
                       wb_en: wb_en_in, branch: branch_in, s: s_in};
    // Only a real, non-bubbled instruction may carry side-effecting control into EXE
    assign live = valid_in & ~bubble;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_out         <= 1'b0;
            ctrl_q            <= '0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            simm24_out        <= '0;
            dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            carry_out         <= 1'b0;
        end else if (!freeze) begin
            valid_out         <= live;
            ctrl_q            <= live ? ctrl_in : '0;
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            imm_out           <= imm_in;
            shift_operand_out <= shift_operand_in;
            simm24_out        <= simm24_in;
            dest_out          <= dest_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            carry_out         <= carry_in;
        end
    end

    assign exe_cmd_out   = ctrl_q.exe_cmd;
    assign mem_read_out  = ctrl_q.mem_read;
    assign mem_write_out = ctrl_q.mem_write;
    assign wb_en_out     = ctrl_q.wb_en;
    assign branch_out    = ctrl_q.branch;
    assign s_out         = ctrl_q.s;

`ifdef ID_EXE_PERF_CNT_EN
    // Flush dominates freeze, freeze dominates bubble: at most one event per edge
    id_exe_perf_counter u_bubble_cnt (.clk(clk), .rst_n(rst_n), .inc(bubble & ~flush & ~freeze), .count(bubble_cnt));
    id_exe_perf_counter u_flush_cnt  (.clk(clk), .rst_n(rst_n), .inc(flush),                     .count(flush_cnt));
    id_exe_perf_counter u_freeze_cnt (.clk(clk), .rst_n(rst_n), .inc(freeze & ~flush),           .count(freeze_cnt));
`endif

endmodule
